// File: rtl/muldiv_unit_p.sv
// Multi-cycle RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, with start/busy/done handshake.
module muldiv_unit_p #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             N
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH:0]     rem_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   result_q;

   logic               a_sgn;
   logic               b_sgn;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               neg_d;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   spec_res;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nx;
   logic [2*WIDTH-1:0] prod_fin;
   logic [WIDTH-1:0]   mul_res;

   logic [WIDTH+1:0]   rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [WIDTH:0]     rem_nx;
   logic [WIDTH-1:0]   quot_nx;
   logic [WIDTH-1:0]   quot_fin;
   logic [WIDTH-1:0]   rem_fin;
   logic [WIDTH-1:0]   div_res;

   // Operand decode for the incoming request
   assign a_sgn = srcA[WIDTH-1] &
                  ((op == 3'b001) | (op == 3'b010) |
                   (op == 3'b100) | (op == 3'b110));
   assign b_sgn = srcB[WIDTH-1] &
                  ((op == 3'b001) | (op == 3'b100) |
                   (op == 3'b110));
   assign a_mag = a_sgn ? -srcA : srcA;
   assign b_mag = b_sgn ? -srcB : srcB;

   // REM/REMU follow the dividend sign; everything else the sign product
   assign neg_d = (op[2] & op[1]) ? a_sgn : (a_sgn ^ b_sgn);

   assign div_zero = op[2] & (srcB == '0);
   assign div_ovf  = op[2] & ~op[0] &
                     (srcA == MINV) & (srcB == '1);
   assign spec_res = div_zero ? (op[1] ? srcA : '1)
                              : (op[1] ? '0 : srcA);

   // Multiply step: conditional add into the upper half, then shift right
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (prod_q[0] ? a_q : '0)};
   assign prod_nx  = {mul_sum, prod_q[WIDTH-1:1]};
   assign prod_fin = neg_q ? -prod_nx : prod_nx;
   assign mul_res  = (op_q == 3'b000) ? prod_fin[WIDTH-1:0]
                                      : prod_fin[2*WIDTH-1:WIDTH];

   // Divide step: dividend/quotient shift through prod_q low half
   assign rem_sh   = {rem_q, prod_q[WIDTH-1]};
   assign div_diff = rem_sh - {2'b00, b_q};
   assign div_ge   = ~div_diff[WIDTH+1];
   assign rem_nx   = div_ge ? div_diff[WIDTH:0] : rem_sh[WIDTH:0];
   assign quot_nx  = {prod_q[WIDTH-2:0], div_ge};
   assign quot_fin = neg_q ? -quot_nx : quot_nx;
   assign rem_fin  = neg_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
   assign div_res  = op_q[1] ? rem_fin : quot_fin;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_q  <= op;
                  neg_q <= neg_d;
                  a_q   <= a_mag;
                  b_q   <= b_mag;
                  cnt_q <= '0;
                  rem_q <= '0;
                  if (div_zero | div_ovf) begin
                     result_q <= spec_res;
                     state_q  <= S_DONE;
                  end else if (op[2]) begin
                     prod_q  <= {{WIDTH{1'b0}}, a_mag};
                     state_q <= S_DIV;
                  end else begin
                     prod_q  <= {{WIDTH{1'b0}}, b_mag};
                     state_q <= S_MUL;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_MUL: begin
               prod_q <= prod_nx;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  result_q <= mul_res;
                  state_q  <= S_DONE;
               end
            end
            S_DIV: begin
               prod_q <= {{WIDTH{1'b0}}, quot_nx};
               rem_q  <= rem_nx;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  result_q <= div_res;
                  state_q  <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy   = (state_q == S_MUL) | (state_q == S_DIV);
   assign done   = (state_q == S_DONE);
   assign Result = result_q;
   assign Zero   = (result_q == '0);
   assign N      = result_q[WIDTH-1];

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Self-checking bench for muldiv_unit_p.
// Scoreboard queue of expected results, popped on each done pulse.
module tb_muldiv_unit_p;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         flush;
   logic [2:0]   op;
   logic [W-1:0] srcA;
   logic [W-1:0] srcB;
   logic         busy;
   logic         done;
   logic [W-1:0] Result;
   logic         Zero;
   logic         N;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   muldiv_unit_p #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .srcA  (srcA),
      .srcB  (srcB),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .Result(Result),
      .Zero  (Zero),
      .N     (N)
   );

   function automatic logic [W-1:0] ref_model(
      input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      longint sb;
      logic [63:0] p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return '1;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return '0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   task automatic start_op(input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] e);
      op    = o;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      exp_q.push_back(e);
   endtask

   // Called in the first cycle after the accepting edge (k = 1)
   task automatic wait_done(input int exp_lat, input int exp_busy,
                            input string name);
      int bc;
      int lat;
      logic [W-1:0] e;
      bc  = 0;
      lat = 0;
      for (int k = 1; k <= 80; k++) begin
         if (busy) bc++;
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      e = exp_q.pop_front();
      checks++;
      if (lat == 0) begin
         failures++;
         $display("FAIL %s timeout: no done within 80 cycles", name);
      end else begin
         if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
         end
         checks++;
         if (bc !== exp_busy) begin
            failures++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, bc, exp_busy);
         end
         checks++;
         if (Result !== e) begin
            failures++;
            $display("FAIL %s result: got %h want %h", name, Result, e);
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e,
                         input int lat, input int bsy, input string name);
      start_op(o, a, b, e);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bsy, name);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, Zero, N, Result} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset state: got b=%b d=%b z=%b n=%b r=%h want 0 0 1 0 0",
                  busy, done, Zero, N, Result);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul;
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32, "mul_7_m3");
      checks++;
      if (N !== 1'b1) begin
         failures++;
         $display("FAIL mul_7_m3 N: got %b want 1", N);
      end
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32, "mulh");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, "mulhu");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 32, "mulhsu");
   endtask

   task automatic test_div;
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 32, "divu");
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 32, "remu");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, "rem_m7_2");
   endtask

   task automatic test_special;
      run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
      run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, 0, "remu_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, "rem_ovf");
      checks++;
      if (Zero !== 1'b1) begin
         failures++;
         $display("FAIL rem_ovf Zero: got %b want 1", Zero);
      end
   endtask

   task automatic test_random;
      logic [2:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           sp;
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         if (i == 5) b = '0;
         sp = o[2] && (b == 0);
         run_op(o, a, b, ref_model(o, a, b), sp ? 1 : 33, sp ? 0 : 32, "random");
      end
   endtask

   task automatic test_flush;
      bit seen;
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 32, "pre_flush");
      op    = 3'd5;
      srcA  = 32'hFFFF_FFFF;
      srcB  = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL flush idle: got busy=%b done=%b want 0 0", busy, done);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL flush done pulse: got 1 want 0");
      end
      checks++;
      if (Result !== 32'd14) begin
         failures++;
         $display("FAIL flush result: got %h want %h", Result, 32'd14);
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      op    = 3'd5;
      srcA  = 32'd1000;
      srcB  = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({busy, done, Zero, Result} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL reset_mid state: got b=%b d=%b z=%b r=%h want 0 0 1 0",
                  busy, done, Zero, Result);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL reset_mid done pulse: got 1 want 0");
      end
   endtask

   task automatic test_start_busy;
      start_op(3'd5, 32'd100, 32'd7, 32'd14);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      op    = 3'd0;
      srcA  = 32'd9;
      srcB  = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      srcA  = 32'd55;
      wait_done(28, 27, "start_busy");
   endtask

   task automatic test_back_to_back;
      start_op(3'd0, 32'd3, 32'd4, 32'd12);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(33, 32, "b2b_mul");
      start_op(3'd5, 32'd12, 32'd4, 32'd3);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(33, 32, "b2b_divu");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = '0;
      srcA  = '0;
      srcB  = '0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_random();
      test_flush();
      test_reset_mid();
      test_start_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
